uart_param_report: RTL and testbench

// - Transmit-side counterpart of the UART parameter-load path: snapshots the live DDS controls and sends them to the host in the load-frame format.
// - Frame (10 bytes): 0x41, {6'b0,wav}, freq[7:0],[15:8],[23:16],{6'b0,freq[25:24]}, phase[7:0],{7'b0,phase[8]}, amp[7:0],{2'b0,amp[13:8]}.
// - Sits between the UART control block (control values) and the byte-level uart_tx (tx_data/tx_flag -> pi_data/pi_flag).

---
 rtl/uart_param_report_pkg.sv | 53 +++++
 rtl/uart_param_report_pacer.sv | 34 +++
 rtl/uart_param_report.sv | 106 ++++++++++
 tb/tb_uart_param_report.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_param_report_pkg.sv
// Shared frame definition for the UART parameter path (load and report directions).
package uart_param_report_pkg;

  localparam logic [7:0] FRAME_HDR = 8'h41;
  localparam int         FRAME_LEN = 10;

  // Byte positions inside a frame
  localparam logic [3:0] IDX_HDR    = 4'd0;
  localparam logic [3:0] IDX_WAV    = 4'd1;
  localparam logic [3:0] IDX_FREQ0  = 4'd2;
  localparam logic [3:0] IDX_FREQ1  = 4'd3;
  localparam logic [3:0] IDX_FREQ2  = 4'd4;
  localparam logic [3:0] IDX_FREQ3  = 4'd5;
  localparam logic [3:0] IDX_PHASE0 = 4'd6;
  localparam logic [3:0] IDX_PHASE1 = 4'd7;
  localparam logic [3:0] IDX_AMP0   = 4'd8;
  localparam logic [3:0] IDX_AMP1   = 4'd9;
  localparam logic [3:0] IDX_LAST   = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } report_state_t;

  typedef struct packed {
    logic [1:0]  wav;
    logic [25:0] freq;
    logic [8:0]  phase;
    logic [13:0] amp;
  } dds_params_t;

  // Byte at position idx of the frame carrying parameter set p
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input dds_params_t p);
    logic [7:0] b;
    case (idx)
      IDX_HDR:    b = FRAME_HDR;
      IDX_WAV:    b = {6'b0, p.wav};
      IDX_FREQ0:  b = p.freq[7:0];
      IDX_FREQ1:  b = p.freq[15:8];
      IDX_FREQ2:  b = p.freq[23:16];
      IDX_FREQ3:  b = {6'b0, p.freq[25:24]};
      IDX_PHASE0: b = p.phase[7:0];
      IDX_PHASE1: b = {7'b0, p.phase[8]};
      IDX_AMP0:   b = p.amp[7:0];
      IDX_AMP1:   b = {2'b0, p.amp[13:8]};
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_param_report_pacer.sv
// Byte pacer: counts clock cycles since the last clear and flags the end of one
// character slot (10 bits plus guard bits) at count GAP_CYCLES-1.
module uart_byte_pacer #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int GUARD_BITS = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  output logic tc
);

  localparam int BIT_CYCLES = CLK_FREQ / UART_BPS;
  localparam int GAP_CYCLES = BIT_CYCLES * (10 + GUARD_BITS);
  localparam int TW         = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TERM = TW'(GAP_CYCLES - 1);

  logic [TW-1:0] count;

  // Count up from the clear point and park at terminal count so it never wraps
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != TERM) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/uart_param_report.sv
// Snapshots the live DDS controls on request and streams them to uart_tx as a
// 10-byte load-format frame, one byte per character slot.
//
// state | meaning
// IDLE  | waiting for report_req (ignored while done is still high)
// SEND  | present frame byte[index] on tx_data with a one-cycle tx_flag
// WAIT  | let the character drain; pacer terminal count ends the slot
// DONE  | last slot over; raise done, drop busy, return to IDLE
module uart_param_report
  import uart_param_report_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int GUARD_BITS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        report_req,
  input  logic [1:0]  wav_select,
  input  logic [25:0] freq_ctrl,
  input  logic [8:0]  phase_ctrl,
  input  logic [13:0] amp_ctrl,
  output logic [7:0]  tx_data,
  output logic        tx_flag,
  output logic        busy,
  output logic        done
);

  report_state_t state;
  dds_params_t   snap;
  logic [3:0]    byte_idx;
  logic [7:0]    cur_byte;
  logic          accept;
  logic          pacer_clear;
  logic          slot_tc;

  // The done cycle counts as part of the frame, so a request there is dropped
  assign accept      = (state == IDLE) && report_req && !done;
  // Restart the slot timer on every entry into SEND so the SEND cycle is slot cycle 0
  assign pacer_clear = accept || ((state == WAIT) && slot_tc);

  uart_byte_pacer #(
    .UART_BPS   (UART_BPS),
    .CLK_FREQ   (CLK_FREQ),
    .GUARD_BITS (GUARD_BITS)
  ) u_pacer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (pacer_clear),
    .tc        (slot_tc)
  );

  // Select the frame byte for the current index from the snapshot
  always_comb begin
    cur_byte = frame_byte(byte_idx, snap);
  end

  // Frame sequencer with registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      snap     <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      tx_flag  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_flag <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            snap     <= '{wav: wav_select, freq: freq_ctrl, phase: phase_ctrl, amp: amp_ctrl};
            busy     <= 1'b1;
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_data <= cur_byte;
          tx_flag <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (slot_tc) begin
            if (byte_idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= SEND;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          byte_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_report.sv
// Scoreboard bench for uart_param_report: expected bytes are queued when a
// request is issued and checked as tx_flag strobes appear.
module tb_uart_param_report;

  localparam int GAP = 110;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        report_req;
  logic [1:0]  wav_select;
  logic [25:0] freq_ctrl;
  logic [8:0]  phase_ctrl;
  logic [13:0] amp_ctrl;
  logic [7:0]  tx_data;
  logic        tx_flag;
  logic        busy;
  logic        done;

  uart_param_report #(
    .UART_BPS   (5_000_000),
    .CLK_FREQ   (50_000_000),
    .GUARD_BITS (1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .report_req (report_req),
    .wav_select (wav_select),
    .freq_ctrl  (freq_ctrl),
    .phase_ctrl (phase_ctrl),
    .amp_ctrl   (amp_ctrl),
    .tx_data    (tx_data),
    .tx_flag    (tx_flag),
    .busy       (busy),
    .done       (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cyc  = 0;
  int last_flag_cyc  = 0;
  int flags_in_frame = 0;
  int total_flags    = 0;
  int done_count     = 0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] exp_q [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [79:0] model_frame(input logic [1:0] w, input logic [25:0] f,
                                              input logic [8:0] p, input logic [13:0] a);
    return {8'h41, 6'b0, w, f[7:0], f[15:8], f[23:16], 6'b0, f[25:24],
            p[7:0], 7'b0, p[8], a[7:0], 2'b0, a[13:8]};
  endfunction

  task automatic push_frame(input logic [79:0] bytes);
    for (int i = 0; i < 10; i++) exp_q.push_back(bytes[79-8*i -: 8]);
  endtask

  // One-cycle request; called just after a rising edge
  task automatic pulse_req(input bit record);
    report_req = 1'b1;
    if (record) req_cyc = cyc;
    @(posedge sys_clk); #1;
    report_req = 1'b0;
  endtask

  task automatic wait_done();
    int base;
    bit seen;
    base = done_count;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge sys_clk); #1;
      if (done_count != base) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_flags(input int n);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(posedge sys_clk); #1;
      if (flags_in_frame >= n) seen = 1;
    end
    if (!seen) chk("flag_timeout", 0, 1);
  endtask

  // Monitor: pop/compare on each strobe, check pacing and the done pulse
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (tx_flag) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flag", 1, 0);
        end else begin
          last_byte = exp_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(last_byte));
        end
        if (flags_in_frame == 0) begin
          chk("first_latency", 32'(cyc - req_cyc), 2);
          chk("busy_in_frame", 32'(busy), 1);
        end else begin
          chk("flag_gap", 32'(cyc - last_flag_cyc), GAP);
        end
        last_flag_cyc = cyc;
        flags_in_frame++;
        total_flags++;
      end
      if (done) begin
        chk("done_gap", 32'(cyc - last_flag_cyc), GAP);
        chk("flags_per_frame", 32'(flags_in_frame), 10);
        chk("busy_at_done", 32'(busy), 0);
        chk("tx_data_hold", 32'(tx_data), 32'(last_byte));
        flags_in_frame = 0;
        done_count++;
      end
    end
  end

  initial begin
    int base_flags;
    sys_rst_n  = 1'b0;
    report_req = 1'b0;
    wav_select = '0;
    freq_ctrl  = '0;
    phase_ctrl = '0;
    amp_ctrl   = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_flag", 32'(tx_flag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // Basic frame, literal expected bytes
    wav_select = 2'd2; freq_ctrl = 26'h2ABCDEF; phase_ctrl = 9'h15A; amp_ctrl = 14'h2001;
    push_frame(80'h41_02_EF_CD_AB_02_5A_01_01_20);
    pulse_req(1);
    wait_done();

    // Snapshot: freq changes mid-frame must not leak in
    wav_select = 2'd1; freq_ctrl = 26'h1234567; phase_ctrl = 9'h0A5; amp_ctrl = 14'h1555;
    push_frame(model_frame(2'd1, 26'h1234567, 9'h0A5, 14'h1555));
    pulse_req(1);
    wait_flags(3);
    freq_ctrl = 26'h0;
    wait_done();
    push_frame(model_frame(2'd1, 26'h0, 9'h0A5, 14'h1555));
    pulse_req(1);
    wait_done();

    // Busy drop: request at 2nd flag and in the done cycle are ignored
    wav_select = 2'd0; freq_ctrl = 26'h0F0F0F0; phase_ctrl = 9'h100; amp_ctrl = 14'h0ABC;
    push_frame(model_frame(2'd0, 26'h0F0F0F0, 9'h100, 14'h0ABC));
    pulse_req(1);
    wait_flags(2);
    pulse_req(0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(posedge sys_clk); #1;
        if (done) seen = 1;
      end
      if (!seen) chk("done_cycle_timeout", 0, 1);
    end
    pulse_req(0);
    // Cycle after done: accepted normally
    wav_select = 2'd3; freq_ctrl = 26'h0000001; phase_ctrl = 9'h001; amp_ctrl = 14'h0001;
    push_frame(model_frame(2'd3, 26'h0000001, 9'h001, 14'h0001));
    pulse_req(1);
    wait_done();

    // Reset abort after the 4th flag
    wav_select = 2'd2; freq_ctrl = 26'h1A5C3E7; phase_ctrl = 9'h0FF; amp_ctrl = 14'h1234;
    push_frame(model_frame(2'd2, 26'h1A5C3E7, 9'h0FF, 14'h1234));
    pulse_req(1);
    wait_flags(4);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_tx_flag", 32'(tx_flag), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_tx_data", 32'(tx_data), 0);
    exp_q.delete();
    flags_in_frame = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    base_flags = total_flags;
    repeat (300) @(posedge sys_clk);
    #1;
    chk("no_flags_after_abort", 32'(total_flags - base_flags), 0);
    chk("idle_after_abort", 32'(busy), 0);

    // Field edges, literal expected bytes
    wav_select = 2'd3; freq_ctrl = 26'h3FFFFFF; phase_ctrl = 9'h1FF; amp_ctrl = 14'h3FFF;
    push_frame(80'h41_03_FF_FF_FF_03_FF_01_FF_3F);
    pulse_req(1);
    wait_done();

    repeat (5) @(posedge sys_clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
